// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle 8-puzzle CPU core:
//   - 4-bit opcode constants OP_NOP..OP_HALT
//   - 3-bit sequencer state encoding (FETCH..HALT)
//   - instruction field bit positions and small field-extraction helpers
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_LDI  = 4'd8;
   localparam logic [3:0] OP_LD   = 4'd9;
   localparam logic [3:0] OP_ST   = 4'd10;
   localparam logic [3:0] OP_JMP  = 4'd11;
   localparam logic [3:0] OP_JZ   = 4'd12;
   localparam logic [3:0] OP_JNZ  = 4'd13;
   localparam logic [3:0] OP_RSV  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int DST_MSB  = 11;
   localparam int DST_LSB  = 8;
   localparam int SRC0_MSB = 7;
   localparam int SRC0_LSB = 4;
   localparam int SRC1_MSB = 3;
   localparam int SRC1_LSB = 0;
   localparam int IMM_MSB  = 7;
   localparam int IMM_LSB  = 0;

   function automatic logic [3:0] f_opcode(input logic [15:0] ir);
      return ir[OP_MSB:OP_LSB];
   endfunction

   // Opcodes 1..7 are the ALU group: they write dst and update zf.
   function automatic logic f_is_alu(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_SHR);
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// ----------------------------------------------------------------------------
// cpu_regfile
// 16 x DATA_W register file, no hardwired zero register.
// Ports:
//   clk, rst_n          clock / async active-low reset (all registers -> 0)
//   raddr0_i/rdata0_o   asynchronous read port 0
//   raddr1_i/rdata1_o   asynchronous read port 1
//   we_i/waddr_i/wdata_i synchronous write port
// ----------------------------------------------------------------------------
module cpu_regfile #(
   parameter int DATA_W = 40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        raddr0_i,
   output logic [DATA_W-1:0] rdata0_o,
   input  logic [3:0]        raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic              we_i,
   input  logic [3:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i
);

   logic [DATA_W-1:0] regs_q [16];

   // Register storage with single synchronous write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata0_o = regs_q[raddr0_i];
   assign rdata1_o = regs_q[raddr1_i];

endmodule

// File: rtl/cpu_core_mc.sv
// ----------------------------------------------------------------------------
// cpu_core_mc
// Multi-cycle CPU core: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] sequencer,
// 16-entry register file, inline ALU, zero flag and an absorbing HALT state.
// Instruction and data memories are reached through req/ack ports, so both
// may insert wait states.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   imem_req/imem_addr              fetch request, address = pc
//   imem_ack/imem_data              fetch completion and instruction word
//   dmem_req/dmem_we/dmem_addr/dmem_wdata  data access request (we=1 store)
//   dmem_ack/dmem_rdata             access completion and load data
//   halted, pc_dbg                  status: in HALT, current pc
// Optional (macro CPU_PERF_CNT_EN):
//   cycle_cnt   non-HALT cycle counter, 32-bit wrapping
//   instret_cnt retired-instruction counter, 32-bit wrapping
// ----------------------------------------------------------------------------
module cpu_core_mc
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 40,
   parameter int PC_W    = 6,
   parameter int DADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [15:0]        imem_data,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic               dmem_ack,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic               halted,
   output logic [PC_W-1:0]    pc_dbg
`ifdef CPU_PERF_CNT_EN
   ,
   output logic [31:0]        cycle_cnt,
   output logic [31:0]        instret_cnt
`endif
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic              zf_q, zf_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic              imem_req_q, dmem_req_q, dmem_we_q, halted_q;

   logic [3:0]        opc_s;
   logic [DATA_W-1:0] rd0_s, rd1_s, alu_s;
   logic [PC_W-1:0]   target_s;
   logic              rf_we_s;

   assign opc_s    = f_opcode(ir_q);
   assign target_s = ir_q[PC_W-1:0];

   cpu_regfile #(.DATA_W(DATA_W)) u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .raddr0_i (ir_q[SRC0_MSB:SRC0_LSB]),
      .rdata0_o (rd0_s),
      .raddr1_i (ir_q[SRC1_MSB:SRC1_LSB]),
      .rdata1_o (rd1_s),
      .we_i     (rf_we_s),
      .waddr_i  (ir_q[DST_MSB:DST_LSB]),
      .wdata_i  (res_q)
   );

   // ALU on the latched operands.
   always_comb begin
      alu_s = '0;
      case (opc_s)
         OP_ADD:  alu_s = a_q + b_q;
         OP_SUB:  alu_s = a_q - b_q;
         OP_AND:  alu_s = a_q & b_q;
         OP_OR:   alu_s = a_q | b_q;
         OP_XOR:  alu_s = a_q ^ b_q;
         OP_SHL:  alu_s = {a_q[DATA_W-2:0], 1'b0};
         OP_SHR:  alu_s = {1'b0, a_q[DATA_W-1:1]};
         default: alu_s = '0;
      endcase
   end

   // Sequencer next-state and datapath register updates.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      zf_d    = zf_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      rf_we_s = 1'b0;
      case (state_q)
         ST_FETCH: begin
            // An ack is only honoured while our request is actually up.
            if (imem_req_q && imem_ack) begin
               ir_d    = imem_data;
               pc_d    = pc_q + PC_W'(1);
               state_d = ST_DECODE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: begin
            a_d     = rd0_s;
            b_d     = rd1_s;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (f_is_alu(opc_s)) begin
               res_d   = alu_s;
               zf_d    = (alu_s == '0);
               state_d = ST_WB;
            end else begin
               case (opc_s)
                  OP_LDI: begin
                     res_d   = DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
                     state_d = ST_WB;
                  end
                  OP_LD, OP_ST: state_d = ST_MEM;
                  OP_JMP: begin
                     pc_d    = target_s;
                     state_d = ST_FETCH;
                  end
                  OP_JZ: begin
                     if (zf_q) pc_d = target_s;
                     else      pc_d = pc_q;
                     state_d = ST_FETCH;
                  end
                  OP_JNZ: begin
                     if (!zf_q) pc_d = target_s;
                     else       pc_d = pc_q;
                     state_d = ST_FETCH;
                  end
                  OP_HALT: state_d = ST_HALT;
                  default: state_d = ST_FETCH;
               endcase
            end
         end
         ST_MEM: begin
            if (dmem_req_q && dmem_ack) begin
               if (opc_s == OP_LD) begin
                  res_d   = dmem_rdata;
                  state_d = ST_WB;
               end else begin
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_WB: begin
            rf_we_s = 1'b1;
            state_d = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
   end

   // State, datapath registers and request outputs; requests are derived
   // from the next state so they are up in the first cycle of FETCH/MEM
   // and drop the cycle after the ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         pc_q       <= '0;
         ir_q       <= 16'h0000;
         zf_q       <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         zf_q       <= zf_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         imem_req_q <= (state_d == ST_FETCH);
         dmem_req_q <= (state_d == ST_MEM);
         dmem_we_q  <= (state_d == ST_MEM) && (opc_s == OP_ST);
         halted_q   <= (state_d == ST_HALT);
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   // Operand registers stay constant throughout MEM, keeping addr/wdata stable.
   assign dmem_addr  = b_q[DADDR_W-1:0];
   assign dmem_wdata = a_q;
   assign halted     = halted_q;
   assign pc_dbg     = pc_q;

`ifdef CPU_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, instret_cnt_q;

   // Performance counters: non-HALT cycles and instructions retired on the
   // return to FETCH (entering HALT is not a retirement).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q   <= 32'd0;
         instret_cnt_q <= 32'd0;
      end else begin
         if (state_q != ST_HALT) cycle_cnt_q <= cycle_cnt_q + 32'd1;
         else                    cycle_cnt_q <= cycle_cnt_q;
         if ((state_d == ST_FETCH) &&
             ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)))
            instret_cnt_q <= instret_cnt_q + 32'd1;
         else
            instret_cnt_q <= instret_cnt_q;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`endif

endmodule
